// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: a shadow register set feeds an active copy that is swapped
// at frame boundaries, then one digit per prescaler tick is driven with optional blanking.
module seg_scan_ctrl #(
   parameter int unsigned CPU_WIDTH  = 16,
   parameter int unsigned DIGITS     = 8,
   parameter int unsigned SCAN_DIV   = 1000,
   parameter int unsigned ACTIVE_LOW = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 we,
   input  logic [1:0]           addr,
   input  logic [CPU_WIDTH-1:0] wdata,
   output logic [DIGITS-1:0]    tube_en,
   output logic [7:0]           seg_led,
   output logic                 frame_done
);

   localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
   localparam logic [31:0]       VIS_MASK = 32'((64'd1 << (4 * DIGITS)) - 64'd1);
   localparam bit                POL      = (ACTIVE_LOW != 0);
   localparam logic [DIGITS-1:0] TUBE_OFF = {DIGITS{POL}};
   localparam logic [7:0]        SEG_OFF  = {8{POL}};
   localparam logic [1:0]        A_LO = 2'd0, A_HI = 2'd1, A_CTRL = 2'd2, A_DP = 2'd3;

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [31:0]       shd_data_q, shd_data_d, act_data_q, act_data_d;
   logic [7:0]        shd_dp_q, shd_dp_d, act_dp_q, act_dp_d;
   logic              pend_q, pend_d;
   logic              en_q, en_d, lzs_q, lzs_d;
   logic [7:0]        blank_q, blank_d;
   logic [DIGITS-1:0] tube_q, tube_d;
   logic [7:0]        seg_q, seg_d;
   logic              fdone_q, fdone_d;

   logic              tick, wrap, blank_dig;
   logic [IDX_W-1:0]  idx_nxt;
   logic [31:0]       src_data, vis;
   logic [7:0]        src_dp, seg_raw;
   logic [4:0]        shamt;
   logic [DIGITS-1:0] tube_raw;
   logic              unused_wdata;

   assign unused_wdata = ^wdata;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;
         default: hex7 = 7'h71;
      endcase
   endfunction

   // Next-state: scan timing, frame-boundary swap, register writes, then disable override
   always_comb begin
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      shd_data_d = shd_data_q;
      shd_dp_d   = shd_dp_q;
      act_data_d = act_data_q;
      act_dp_d   = act_dp_q;
      pend_d     = pend_q;
      en_d       = en_q;
      lzs_d      = lzs_q;
      blank_d    = blank_q;
      tube_d     = tube_q;
      seg_d      = seg_q;
      fdone_d    = 1'b0;

      tick     = en_q && (cnt_q == CNT_LAST);
      wrap     = tick && (idx_q == IDX_LAST);
      idx_nxt  = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      // At a swapping boundary digit 0 must already show the incoming data
      src_data = (wrap && pend_q) ? shd_data_q : act_data_q;
      src_dp   = (wrap && pend_q) ? shd_dp_q : act_dp_q;
      shamt    = 5'(idx_nxt) << 2;
      vis      = (src_data & VIS_MASK) >> shamt;
      blank_dig = blank_q[3'(idx_nxt)] || (lzs_q && (idx_nxt != '0) && (vis == '0));
      seg_raw  = {src_dp[3'(idx_nxt)], blank_dig ? 7'd0 : hex7(vis[3:0])};
      tube_raw = DIGITS'(1) << idx_nxt;

      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      if (tick) begin
         idx_d   = idx_nxt;
         tube_d  = tube_raw ^ TUBE_OFF;
         seg_d   = seg_raw ^ SEG_OFF;
         fdone_d = wrap;
      end
      if (wrap && pend_q) begin
         act_data_d = shd_data_q;
         act_dp_d   = shd_dp_q;
         pend_d     = 1'b0;
      end

      if (we) begin
         case (addr)
            A_LO:   begin shd_data_d[15:0]  = wdata[15:0]; pend_d = 1'b1; end
            A_HI:   begin shd_data_d[31:16] = wdata[15:0]; pend_d = 1'b1; end
            A_DP:   begin shd_dp_d          = wdata[7:0];  pend_d = 1'b1; end
            default: begin
               en_d    = wdata[0];
               lzs_d   = wdata[1];
               blank_d = wdata[15:8];
            end
         endcase
      end

      if (!en_q) begin
         cnt_d      = '0;
         idx_d      = IDX_LAST;
         tube_d     = TUBE_OFF;
         seg_d      = SEG_OFF;
         fdone_d    = 1'b0;
         act_data_d = shd_data_q;
         act_dp_d   = shd_dp_q;
         pend_d     = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q      <= '0;
         idx_q      <= IDX_LAST;
         shd_data_q <= '0;
         shd_dp_q   <= '0;
         act_data_q <= '0;
         act_dp_q   <= '0;
         pend_q     <= 1'b0;
         en_q       <= 1'b1;
         lzs_q      <= 1'b0;
         blank_q    <= '0;
         tube_q     <= TUBE_OFF;
         seg_q      <= SEG_OFF;
         fdone_q    <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         shd_data_q <= shd_data_d;
         shd_dp_q   <= shd_dp_d;
         act_data_q <= act_data_d;
         act_dp_q   <= act_dp_d;
         pend_q     <= pend_d;
         en_q       <= en_d;
         lzs_q      <= lzs_d;
         blank_q    <= blank_d;
         tube_q     <= tube_d;
         seg_q      <= seg_d;
         fdone_q    <= fdone_d;
      end
   end

   assign tube_en    = tube_q;
   assign seg_led    = seg_q;
   assign frame_done = fdone_q;

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter CPU_WIDTH, default 16, bus data width (>=16).
REQ-002 SHALL have parameter DIGITS, default 8, number of digits scanned (1..8).
REQ-003 SHALL have parameter SCAN_DIV, default 1000, clk cycles per digit slot (>=2).
REQ-004 SHALL have parameter ACTIVE_LOW, default 0; 1 inverts every bit of tube_en and seg_led.
REQ-005 SHALL use one clock and an asynchronous active-high reset.
REQ-006 clk  input  1  system clock; all state on rising edge.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 we  input  1  register write strobe, one write per cycle high.
REQ-009 addr  input  2  register select: 0 DATA_LO, 1 DATA_HI, 2 CTRL, 3 DP.
REQ-010 wdata  input  CPU_WIDTH  write data; only bits [15:0] used.
REQ-011 tube_en  output  DIGITS  one-hot digit enable, registered.
REQ-012 seg_led  output  8  segments {dp,g,f,e,d,c,b,a}, registered.
REQ-013 frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-014 Registers SHALL be: shadow data[31:0] (DATA_LO = [15:0], DATA_HI = [31:16]); shadow dp[7:0] (DP wdata[7:0]); CTRL wdata bit0 EN, bit1 LZS (leading-zero suppress), bits[15:8] blank mask; active data/dp copies.
REQ-015 Writes to DATA_LO/DATA_HI/DP SHALL update the shadow copy and set a pending flag; CTRL writes SHALL take effect the next cycle.
REQ-016 Prescaler cnt SHALL count 0..SCAN_DIV-1 and wrap; tick = (cnt==SCAN_DIV-1) with EN=1.
REQ-017 Digit index idx SHALL advance on tick, wrapping DIGITS-1 -> 0; the wrap tick is the frame boundary.
REQ-018 At a frame boundary with pending=1, shadow data/dp SHALL be copied to active and pending cleared in the same cycle; digit 0 of that frame SHALL show the new data.
REQ-019 A write coinciding with a frame-boundary transfer SHALL copy the pre-write shadow value, store the written value in shadow, and leave pending=1.
REQ-020 On each tick, tube_en SHALL become one-hot(new idx) and seg_led SHALL become the code for nibble active[4*idx+3:4*idx], bit7 = active dp[idx].
REQ-021 Hex codes (gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 B=7C C=39 D=5E E=79 F=71.
REQ-022 Digit i SHALL be blanked (seg_led[6:0]=0, dp kept) if blank mask bit i=1, or LZS=1, i>0 and all active nibbles i..DIGITS-1 are zero.
REQ-023 frame_done SHALL be 1 exactly in the cycle after a frame-boundary tick, otherwise 0.
REQ-024 While EN=0: cnt=0, idx=DIGITS-1, tube_en and seg_led inactive (all 0 before polarity), frame_done=0, shadow copied to active every cycle, pending=0.
REQ-025 EN 0 -> 1 SHALL cause the first tick after SCAN_DIV cycles, displaying digit 0.
REQ-026 Nibbles above DIGITS-1 SHALL be stored but never displayed.

Reset
REQ-027 rst SHALL asynchronously set cnt=0, idx=DIGITS-1, shadow/active data=0, dp=0, pending=0, CTRL EN=1 LZS=0 blank=0.
REQ-028 During/after reset until first tick, tube_en=0, seg_led=0 (all-ones if ACTIVE_LOW=1), frame_done=0.
REQ-029 rst asserted mid-frame SHALL abort the scan and discard pending writes.

Verification (DIGITS=4, SCAN_DIV=4)
REQ-030 Release reset, no writes -> tube_en 0001,0010,0100,1000,0001 at 4-cycle spacing, seg_led=3F each, frame_done pulse after each wrap.
REQ-031 Write DATA_LO=0x1A8F mid-frame -> current frame unchanged; next frame digits 0..3 show 71,7F,77,06.
REQ-032 Write DATA_LO in the frame-boundary cycle -> that frame shows old data, next frame shows new, pending cleared then.
REQ-033 CTRL=0x0003, DATA_LO=0x0005 -> digit0=6D, digits1..3 seg_led=00; DP=0x02 -> digit1 seg_led=80.
REQ-034 CTRL=0x0000 for 10 cycles then 0x0001 -> outputs 0 while disabled, DATA write visible immediately at first tick after SCAN_DIV cycles.
REQ-035 ACTIVE_LOW=1 build, reset -> tube_en=1111, seg_led=FF; first tick -> tube_en=1110, seg_led=C0.
